key_sched: RTL and testbench
============================

KEY_SCHED -- requirements
Module: key_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of key-FIFO entries (a power of two).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, which sets the maximum number of WAIT cycles before an error is raised.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port valid_key  input  1  one-cycle strobe marking that key is valid.
REQ-006 The block SHALL have port key  input  4  keypad code from the requester.
REQ-007 The block SHALL have port dp_valid  output  1  one-cycle issue strobe to the downstream FSMD datapath.
REQ-008 The block SHALL have port dp_key  output  4  key code issued to the datapath, meaningful only while dp_valid is 1.
REQ-009 The block SHALL have port dp_done  input  1  one-cycle completion pulse from the datapath.
REQ-010 The block SHALL have port dp_result  input  8  datapath result, valid while dp_done is 1.
REQ-011 The block SHALL have port result  output  8  last captured datapath result.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse, high the cycle after result updates.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse on datapath timeout.
REQ-014 The block SHALL have port ovf  output  1  sticky flag set when a key is dropped because the FIFO is full.
REQ-015 The block SHALL have port count  output  $clog2(DEPTH)+1  number of keys currently queued.

Function
REQ-016 On each rising edge where valid_key=1 and count<DEPTH, key SHALL be pushed to the FIFO tail.
REQ-017 On each rising edge where valid_key=1 and count=DEPTH with no pop that cycle, the key SHALL be dropped and ovf set to 1.
REQ-018 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged, including when the FIFO is full.
REQ-019 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-020 In IDLE, the FSM SHALL move to ISSUE if count>0, otherwise stay in IDLE.
REQ-021 In ISSUE, dp_valid SHALL be 1 and dp_key SHALL equal the FIFO head; the head SHALL be popped, the timeout counter cleared, and the next state SHALL be WAIT.
REQ-022 In WAIT, if dp_done=1, result SHALL capture dp_result, done SHALL pulse for one cycle and the next state SHALL be IDLE.
REQ-023 In WAIT, if dp_done=0, the timeout counter SHALL increment; when it reaches TIMEOUT, err SHALL pulse for one cycle and the next state SHALL be IDLE, with result unchanged.
REQ-024 A dp_done pulse outside WAIT SHALL be ignored: no result change and no done pulse.
REQ-025 Latency: a key accepted at edge k into an empty FIFO while in IDLE SHALL produce dp_valid=1 in the cycle following edge k+1.
REQ-026 There SHALL be at most one outstanding issue; the next dp_valid SHALL occur no earlier than the second cycle after the done or err pulse.
REQ-027 Keys SHALL be issued strictly in arrival order; FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 dp_valid, done and err SHALL never be high for two consecutive cycles.

Reset
REQ-029 While rstn=0, the block SHALL asynchronously set state to IDLE, empty the FIFO (count=0, pointers at 0) and clear the timeout counter.
REQ-030 While rstn=0, the outputs SHALL be dp_valid=0, dp_key=0, result=8'h00, done=0, err=0, ovf=0.
REQ-031 A reset asserted mid-WAIT SHALL abandon the outstanding issue; a dp_done arriving after reset release SHALL be ignored per REQ-024.
REQ-032 ovf SHALL clear only on reset.

Structure
REQ-033 Package key_sched_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT), KEY_W=4, RES_W=8 and the DEPTH and TIMEOUT defaults.
REQ-034 The FIFO SHALL be a separate sub-module key_fifo, with push/pop/full/empty/count ports, instantiated once.
REQ-035 The FSM and timeout counter SHALL reside in key_sched; all outputs SHALL be registered.

Verification
REQ-036 Bench: reset, then single key 4 with dp_done returned 3 cycles after dp_valid with dp_result=8'h2A -> dp_key=4, result=8'h2A, one done pulse.
REQ-037 Bench: keys 4,0,1,3,2,5 on consecutive cycles while the datapath is busy -> first four queued, 2 and 5 dropped, ovf=1, issue order 4,0,1,3.
REQ-038 Bench: issue and never assert dp_done -> err pulse exactly TIMEOUT=15 cycles into WAIT, result unchanged, FSM back in IDLE.
REQ-039 Bench: FIFO full (count=4) plus valid_key during ISSUE -> key accepted, count stays 4, ovf stays 0.
REQ-040 Bench: rstn pulled low during WAIT, then stray dp_done after release -> no done pulse, result=8'h00, count=0.
REQ-041 Bench: spurious dp_done in IDLE -> result unchanged, no done pulse.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and defaults for the keypad scheduler and its key FIFO.
package key_sched_pkg;

  localparam int KEY_W       = 4;
  localparam int RES_W       = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/key_fifo.sv
// Key FIFO: power-of-two depth, pointers wrap naturally, and a push and a pop
// in the same cycle both take effect (including when full).
module key_fifo
  import key_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [KEY_W-1:0]         wdata,
  output logic [KEY_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Write the pushed key into the tail slot.
  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Advance pointers and the occupancy count.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/key_sched.sv
// Keypad scheduler: queues keys, issues them one at a time to a datapath,
// waits for completion or times out, and reports the captured result.
module key_sched
  import key_sched_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_key,
  input  logic [KEY_W-1:0]       key,
  output logic                   dp_valid,
  output logic [KEY_W-1:0]       dp_key,
  input  logic                   dp_done,
  input  logic [RES_W-1:0]       dp_result,
  output logic [RES_W-1:0]       result,
  output logic                   done,
  output logic                   err,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [TW-1:0]    tmr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [KEY_W-1:0] head;

  // The head leaves the FIFO at the end of the ISSUE cycle; a key arriving
  // while full is still accepted in that cycle because a slot frees up.
  assign pop  = (state == ISSUE);
  assign push = valid_key && (!full || pop);

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (key),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow: set whenever a key is dropped, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          ovf <= 1'b0;
    else if (valid_key && full && !pop) ovf <= 1'b1;
  end

  // Scheduler FSM with timeout counter and registered datapath/status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tmr      <= '0;
      dp_valid <= 1'b0;
      dp_key   <= '0;
      result   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so each can only be a
      // single-cycle pulse set by the branch below.
      dp_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state    <= ISSUE;
            dp_valid <= 1'b1;
            dp_key   <= head;
          end
        end
        ISSUE: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            result <= dp_result;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
            if (tmr + TW'(1) == TW'(TIMEOUT)) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched.sv
// Self-checking bench for key_sched: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_key_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid_key = 1'b0;
  logic [3:0] key = '0;
  logic       dp_done = 1'b0;
  logic [7:0] dp_result = '0;
  logic       dp_valid;
  logic [3:0] dp_key;
  logic [7:0] result;
  logic       done;
  logic       err;
  logic       ovf;
  logic [2:0] count;

  key_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_key (valid_key),
    .key       (key),
    .dp_valid  (dp_valid),
    .dp_key    (dp_key),
    .dp_done   (dp_done),
    .dp_result (dp_result),
    .result    (result),
    .done      (done),
    .err       (err),
    .ovf       (ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // Reference model: queued keys, sticky overflow, last result, outstanding issue.
  int         q[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_result = '0;
  bit         m_out = 1'b0;
  int         issue_cyc = -100;
  int         pend_done_cyc = -1;
  logic [7:0] pend_res = '0;
  int         next_delay = 0;
  logic [7:0] next_res = '0;
  bit         rand_mode = 1'b0;
  bit         stray = 1'b0;

  // Expected outputs for the current cycle.
  bit         e_valid = 1'b0;
  bit         e_done = 1'b0;
  bit         e_err = 1'b0;
  logic [3:0] e_key = '0;

  // Observation logs for scenario-level checks.
  int obs_keys[$];
  int done_seen = 0;
  int last_valid_cyc = -100;
  int last_err_cyc = -200;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic compare_outputs();
    chk("dp_valid", 8'(dp_valid), 8'(e_valid));
    if (e_valid) chk("dp_key", 8'(dp_key), 8'(e_key));
    chk("done",   8'(done),     8'(e_done));
    chk("err",    8'(err),      8'(e_err));
    chk("result", result,       m_result);
    chk("ovf",    8'(ovf),      8'(m_ovf));
    chk("count",  8'(count),    8'(q.size()));
    if (dp_valid) begin
      obs_keys.push_back(int'(dp_key));
      last_valid_cyc = t;
    end
    if (done) done_seen++;
    if (err)  last_err_cyc = t;
  endtask

  // Advance the model across the edge ending cycle t, given that cycle's inputs.
  task automatic model_step(input bit vk, input logic [3:0] k, input bit dn,
                            input logic [7:0] dr);
    bit         pop_now;
    bit         idle_now;
    bit         acc;
    int         n;
    bit         n_valid;
    bit         n_done;
    bit         n_err;
    logic [3:0] n_key;
    pop_now  = e_valid;
    idle_now = !m_out;
    n        = q.size();
    n_valid  = 1'b0;
    n_done   = 1'b0;
    n_err    = 1'b0;
    n_key    = e_key;
    if (m_out && t > issue_cyc) begin
      if (dn) begin
        n_done   = 1'b1;
        m_result = dr;
        m_out    = 1'b0;
      end else if (t == issue_cyc + TIMEOUT) begin
        n_err = 1'b1;
        m_out = 1'b0;
      end
    end
    if (idle_now && n > 0) begin
      n_valid       = 1'b1;
      n_key         = 4'(q[0]);
      m_out         = 1'b1;
      issue_cyc     = t + 1;
      pend_done_cyc = (next_delay > 0) ? t + 1 + next_delay : -1;
      pend_res      = next_res;
      if (rand_mode) begin
        next_delay = $urandom_range(0, 17);
        next_res   = 8'($urandom);
      end
    end
    acc = vk && (n < DEPTH || pop_now);
    if (pop_now) void'(q.pop_front());
    if (acc) q.push_back(int'(k));
    else if (vk) m_ovf = 1'b1;
    e_valid = n_valid;
    e_done  = n_done;
    e_err   = n_err;
    e_key   = n_key;
  endtask

  task automatic cycle(input bit vk, input logic [3:0] k);
    bit         dn;
    logic [7:0] dr;
    dn    = (t == pend_done_cyc) || stray;
    dr    = (t == pend_done_cyc) ? pend_res : 8'($urandom);
    stray = 1'b0;
    valid_key = vk;
    key       = k;
    dp_done   = dn;
    dp_result = dr;
    model_step(vk, k, dn, dr);
    @(posedge clk);
    @(negedge clk);
    t++;
    compare_outputs();
  endtask

  task automatic do_reset(input bit async_chk);
    rstn      = 1'b0;
    valid_key = 1'b0;
    dp_done   = 1'b0;
    q.delete();
    m_ovf         = 1'b0;
    m_result      = '0;
    m_out         = 1'b0;
    pend_done_cyc = -1;
    e_valid       = 1'b0;
    e_done        = 1'b0;
    e_err         = 1'b0;
    e_key         = '0;
    #1;
    if (async_chk) begin
      compare_outputs();
      chk("rst_async_dp_key", 8'(dp_key), 8'h00);
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    chk("rst_dp_key", 8'(dp_key), 8'h00);
    rstn = 1'b1;
  endtask

  logic [3:0] burst[6]     = '{4'd4, 4'd0, 4'd1, 4'd3, 4'd2, 4'd5};
  int         exp_order[5] = '{7, 4, 0, 1, 3};

  initial begin
    // Reset state.
    do_reset(1'b0);

    // Single key 4, completion 3 cycles after issue with result 2A.
    next_delay = 3;
    next_res   = 8'h2A;
    done_seen  = 0;
    obs_keys.delete();
    cycle(1'b1, 4'd4);
    repeat (10) cycle(1'b0, 4'd0);
    chk("single_done_pulses", 8'(done_seen), 8'd1);
    chk("single_result", result, 8'h2A);
    chk("single_issues", 8'(obs_keys.size()), 8'd1);
    if (obs_keys.size() > 0) chk("single_key", 8'(obs_keys[0]), 8'd4);

    // Burst of six keys while the datapath is busy: four queued, two dropped.
    obs_keys.delete();
    next_delay = 12;
    next_res   = 8'h11;
    cycle(1'b1, 4'd7);
    cycle(1'b0, 4'd0);
    next_delay = 2;
    next_res   = 8'h33;
    cycle(1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, burst[i]);
    chk("burst_ovf", 8'(ovf), 8'd1);
    repeat (30) cycle(1'b0, 4'd0);
    chk("burst_issues", 8'(obs_keys.size()), 8'd5);
    for (int i = 0; i < 5 && i < obs_keys.size(); i++)
      chk("burst_order", 8'(obs_keys[i]), 8'(exp_order[i]));
    chk("burst_result", result, 8'h33);

    // Issue with no completion: err exactly TIMEOUT cycles into WAIT.
    next_delay = 0;
    cycle(1'b1, 4'd9);
    repeat (20) cycle(1'b0, 4'd0);
    chk("timeout_gap", 8'(last_err_cyc - last_valid_cyc), 8'(TIMEOUT + 1));
    chk("timeout_result", result, 8'h33);

    // Reset in the middle of WAIT, then a stray completion after release.
    next_delay = 0;
    cycle(1'b1, 4'd6);
    repeat (6) cycle(1'b0, 4'd0);
    do_reset(1'b1);
    done_seen = 0;
    stray     = 1'b1;
    cycle(1'b0, 4'd0);
    repeat (4) cycle(1'b0, 4'd0);
    chk("post_rst_done", 8'(done_seen), 8'd0);
    chk("post_rst_result", result, 8'h00);
    chk("post_rst_count", 8'(count), 8'd0);

    // Full FIFO plus a push during ISSUE: accepted, count stays, no overflow.
    next_delay = 10;
    next_res   = 8'h5A;
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i));
    for (int i = 0; i < 40 && !dp_valid; i++) cycle(1'b0, 4'd0);
    chk("full_issue_seen", 8'(dp_valid), 8'd1);
    chk("full_count_before", 8'(count), 8'd4);
    cycle(1'b1, 4'hE);
    chk("full_count_after", 8'(count), 8'd4);
    chk("full_ovf", 8'(ovf), 8'd0);
    next_delay = 1;
    repeat (40) cycle(1'b0, 4'd0);

    // Spurious completion while idle.
    done_seen = 0;
    stray     = 1'b1;
    cycle(1'b0, 4'd0);
    repeat (3) cycle(1'b0, 4'd0);
    chk("idle_done", 8'(done_seen), 8'd0);
    chk("idle_result", result, 8'h5A);

    // Random traffic with random datapath latency and stray completions.
    rand_mode  = 1'b1;
    next_delay = $urandom_range(0, 17);
    next_res   = 8'($urandom);
    repeat (600) begin
      stray = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 2) == 0, 4'($urandom));
    end
    repeat (60) cycle(1'b0, 4'd0);
    chk("drain_count", 8'(count), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
